// File: rtl/acc_buf_pkg.sv
// Shared types and saturating-add helpers for the acc_buffer output accumulator.
// Saturation helpers are used only when ACC_BUF_SAT_EN is defined.
package acc_buf_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Widest lane supported by the saturation helpers; lanes sign-extend into this.
    localparam int unsigned SAT_W_MAX = 64;

    typedef logic signed [SAT_W_MAX:0] sat_wide_t;

    function automatic sat_wide_t sat_max(input int unsigned w);
        return (sat_wide_t'(1'b1) <<< (w - 32'd1)) - sat_wide_t'(1'b1);
    endfunction

    function automatic sat_wide_t sat_min(input int unsigned w);
        return -(sat_wide_t'(1'b1) <<< (w - 32'd1));
    endfunction

    // Returns {overflow, result}; result is clamped to the signed range of a w-bit value.
    function automatic logic [SAT_W_MAX:0] sat_add(
        input logic signed [SAT_W_MAX-1:0] a,
        input logic signed [SAT_W_MAX-1:0] b,
        input int unsigned                 w
    );
        sat_wide_t              sum;
        sat_wide_t              max_v;
        sat_wide_t              min_v;
        logic                   ovf;
        logic [SAT_W_MAX:0]     res;
        sum   = sat_wide_t'(a) + sat_wide_t'(b);
        max_v = sat_max(w);
        min_v = sat_min(w);
        if (sum > max_v) begin
            res = max_v;
            ovf = 1'b1;
        end else if (sum < min_v) begin
            res = min_v;
            ovf = 1'b1;
        end else begin
            res = sum;
            ovf = 1'b0;
        end
        return {ovf, res[SAT_W_MAX-1:0]};
    endfunction

endpackage

// File: rtl/acc_lane.sv
// Single-column store/accumulate adder for acc_buffer.
// ACC_BUF_SAT_EN selects signed saturating adds and exposes a per-lane overflow bit.
module acc_lane
    import acc_buf_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              acc_mode,
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] in_val,
`ifdef ACC_BUF_SAT_EN
    output logic              ovf,
`endif
    output logic [DATA_W-1:0] new_val
);

`ifdef ACC_BUF_SAT_EN
    logic signed [SAT_W_MAX-1:0] old_ext_s;
    logic signed [SAT_W_MAX-1:0] in_ext_s;
    logic [SAT_W_MAX:0]          sat_s;
    logic                        sat_unused_s;

    assign old_ext_s    = SAT_W_MAX'(signed'(old_val));
    assign in_ext_s     = SAT_W_MAX'(signed'(in_val));
    assign sat_s        = sat_add(old_ext_s, in_ext_s, DATA_W);
    assign sat_unused_s = ^sat_s;

    // Store passes input through; accumulate clamps to the lane's signed range.
    always_comb begin
        new_val = in_val;
        ovf     = 1'b0;
        if (acc_mode) begin
            new_val = sat_s[DATA_W-1:0];
            ovf     = sat_s[SAT_W_MAX];
        end else begin
            new_val = in_val;
            ovf     = 1'b0;
        end
    end
`else
    // Store passes input through; accumulate wraps modulo 2^DATA_W.
    always_comb begin
        new_val = in_val;
        if (acc_mode) begin
            new_val = old_val + in_val;
        end else begin
            new_val = in_val;
        end
    end
`endif

endmodule

// File: rtl/acc_buffer.sv
// Single-buffered output accumulator: fills a DEPTH x NUM_COLS tile over one or more
// K-passes, then drains it row by row. ACC_BUF_SAT_EN adds saturation and a sticky ovf port.
module acc_buffer
    import acc_buf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int NUM_COLS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_COLS*DATA_W-1:0]   in_data,
    input  logic                         in_last,
    input  logic                         acc_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_COLS*DATA_W-1:0]   out_data,
    output logic [$clog2(DEPTH)-1:0]     out_row,
`ifdef ACC_BUF_SAT_EN
    output logic                         ovf,
`endif
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(DEPTH - 1);

    state_e                       state_r;
    state_e                       state_next_s;
    logic [NUM_COLS*DATA_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]             wr_ptr_r;
    logic [PTR_W-1:0]             rd_ptr_r;
    logic                         empty_r;
    logic [NUM_COLS*DATA_W-1:0]   row_next_s;
    logic                         accept_s;
    logic                         out_fire_s;
    logic                         wr_last_s;
    logic                         drain_done_s;

    assign accept_s     = in_valid && (state_r == FILL);
    assign out_fire_s   = out_ready && (state_r == DRAIN);
    assign wr_last_s    = (wr_ptr_r == LAST_ROW);
    assign drain_done_s = out_fire_s && (rd_ptr_r == LAST_ROW);

`ifdef ACC_BUF_SAT_EN
    logic [NUM_COLS-1:0] lane_ovf_s;
    logic                ovf_r;
    assign ovf = ovf_r;
`endif

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
        acc_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .acc_mode (acc_mode),
            .old_val  (mem_r[wr_ptr_r][c*DATA_W +: DATA_W]),
            .in_val   (in_data[c*DATA_W +: DATA_W]),
`ifdef ACC_BUF_SAT_EN
            .ovf      (lane_ovf_s[c]),
`endif
            .new_val  (row_next_s[c*DATA_W +: DATA_W])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FILL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: in_last only counts on the final row of a pass.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FILL: begin
                if (accept_s && wr_last_s && in_last) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = FILL;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    state_next_s = FILL;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = FILL;
        endcase
    end

    // Tile storage, pointers and status; finishing a drain clears the tile for the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_r[r] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            empty_r  <= 1'b1;
`ifdef ACC_BUF_SAT_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= row_next_s;
                wr_ptr_r        <= wr_last_s ? '0 : wr_ptr_r + PTR_W'(1);
                empty_r         <= 1'b0;
`ifdef ACC_BUF_SAT_EN
                ovf_r           <= ovf_r | (acc_mode & (|lane_ovf_s));
`endif
            end
            if (drain_done_s) begin
                for (int r = 0; r < DEPTH; r++) begin
                    mem_r[r] <= '0;
                end
                rd_ptr_r <= '0;
                empty_r  <= 1'b1;
`ifdef ACC_BUF_SAT_EN
                ovf_r    <= 1'b0;
`endif
            end else if (out_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    assign in_ready  = (state_r == FILL);
    assign out_valid = (state_r == DRAIN);
    assign full      = (state_r == DRAIN);
    assign empty     = empty_r && (state_r == FILL);
    assign out_data  = mem_r[rd_ptr_r];
    assign out_row   = rd_ptr_r;

endmodule

// File: tb/tb_acc_buffer.sv
// Directed testbench for acc_buffer (DATA_W=32, DEPTH=4, NUM_COLS=2); follows ACC_BUF_SAT_EN.
module tb_acc_buffer;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 4;
    localparam int NUM_COLS = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_COLS*DATA_W-1:0] in_data;
    logic                       in_last;
    logic                       acc_mode;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_COLS*DATA_W-1:0] out_data;
    logic [1:0]                 out_row;
    logic                       full;
    logic                       empty;
`ifdef ACC_BUF_SAT_EN
    logic                       ovf;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    acc_buffer #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .NUM_COLS (NUM_COLS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .acc_mode  (acc_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
`ifdef ACC_BUF_SAT_EN
        .ovf       (ovf),
`endif
        .full      (full),
        .empty     (empty)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the beat is taken on the following posedge.
    task automatic beat(input logic [31:0] d0, input logic [31:0] d1,
                        input logic mode, input logic last);
        check("beat_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = {d1, d0};
        acc_mode = mode;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_row(input logic [1:0] row, input logic [31:0] d0, input logic [31:0] d1);
        check("drain_valid", out_valid, 1'b1);
        check("drain_row", out_row, row);
        check("drain_data", out_data, {d1, d0});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_empty"}, empty, 1'b1);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_full"}, full, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        acc_mode  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check_idle("rst");
        check("rst_out_row", out_row, 2'd0);
        check("rst_out_data", out_data, 64'd0);
`ifdef ACC_BUF_SAT_EN
        check("rst_ovf", ovf, 1'b0);
`endif

        // Store tile, then drain
        beat(32'd1, 32'd2, 1'b0, 1'b0);
        check("t1_empty_cleared", empty, 1'b0);
        beat(32'd3, 32'd4, 1'b0, 1'b0);
        beat(32'd5, 32'd6, 1'b0, 1'b0);
        check("t1_full_early", full, 1'b0);
        beat(32'd7, 32'd8, 1'b0, 1'b1);
        check("t1_full", full, 1'b1);
        check("t1_in_ready", in_ready, 1'b0);
        for (int r = 0; r < DEPTH; r++) begin
            drain_row(2'(r), 32'(2*r + 1), 32'(2*r + 2));
        end
        check_idle("t1_after");

        // Two accumulate passes: 10 + 5
        for (int r = 0; r < DEPTH; r++) begin
            beat(32'd10, 32'd10, 1'b1, 1'b0);
        end
        check("t2_pass1_full", full, 1'b0);
        check("t2_pass1_empty", empty, 1'b0);
        for (int r = 0; r < DEPTH; r++) begin
            beat(32'd5, 32'd5, 1'b1, r == DEPTH - 1);
        end
        check("t2_full", full, 1'b1);
        for (int r = 0; r < DEPTH; r++) begin
            drain_row(2'(r), 32'd15, 32'd15);
        end
        check_idle("t2_after");

        // Backpressure at row 1 while upstream pushes during drain
        for (int r = 0; r < DEPTH; r++) begin
            beat(32'(11 + 2*r), 32'(12 + 2*r), 1'b0, r == DEPTH - 1);
        end
        drain_row(2'd0, 32'd11, 32'd12);
        in_valid = 1'b1;
        in_data  = {32'd99, 32'd99};
        acc_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_in_ready", in_ready, 1'b0);
            check("t3_hold_row", out_row, 2'd1);
            check("t3_hold_data", out_data, {32'd14, 32'd13});
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int r = 1; r < DEPTH; r++) begin
            drain_row(2'(r), 32'(11 + 2*r), 32'(12 + 2*r));
        end
        check_idle("t3_after");

        // Zero data, in_last asserted on every row: only the final row ends the tile
        for (int r = 0; r < DEPTH; r++) begin
            beat(32'd0, 32'd0, 1'b0, 1'b1);
            if (r < DEPTH - 1) begin
                check("t4_full_early", full, 1'b0);
            end else begin
                check("t4_full", full, 1'b1);
            end
        end
        for (int r = 0; r < DEPTH; r++) begin
            drain_row(2'(r), 32'd0, 32'd0);
        end
        check_idle("t4_after");

        // Reset mid-fill; accumulate afterwards must see cleared rows
        beat(32'd21, 32'd22, 1'b1, 1'b0);
        beat(32'd23, 32'd24, 1'b1, 1'b0);
        pulse_reset();
        check_idle("t5_fill_rst");
        check("t5_fill_rst_data", out_data, 64'd0);
        for (int r = 0; r < DEPTH; r++) begin
            beat(32'(40 + 2*r), 32'(41 + 2*r), 1'b1, r == DEPTH - 1);
        end
        drain_row(2'd0, 32'd40, 32'd41);
        drain_row(2'd1, 32'd42, 32'd43);
        check("t5_at_row2", out_row, 2'd2);

        // Reset mid-drain at row 2
        pulse_reset();
        check_idle("t5_drain_rst");
        check("t5_drain_rst_row", out_row, 2'd0);
        check("t5_drain_rst_data", out_data, 64'd0);
        for (int r = 0; r < DEPTH; r++) begin
            beat(32'(50 + 2*r), 32'(51 + 2*r), 1'b1, r == DEPTH - 1);
        end
        for (int r = 0; r < DEPTH; r++) begin
            drain_row(2'(r), 32'(50 + 2*r), 32'(51 + 2*r));
        end
        check_idle("t5_after");

        // Signed overflow in accumulate mode, positive and negative
        beat(32'h7FFF_FFF0, 32'hFFFF_FFFB, 1'b1, 1'b0);
        beat(32'h8000_0000, 32'd1, 1'b1, 1'b0);
        beat(32'd1, 32'd1, 1'b1, 1'b0);
        beat(32'd1, 32'd1, 1'b1, 1'b0);
`ifdef ACC_BUF_SAT_EN
        check("t6_ovf_pass1", ovf, 1'b0);
`endif
        beat(32'h0000_0020, 32'd3, 1'b1, 1'b0);
        beat(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        beat(32'd2, 32'd2, 1'b1, 1'b0);
        beat(32'd2, 32'd2, 1'b1, 1'b1);
`ifdef ACC_BUF_SAT_EN
        check("t6_ovf_set", ovf, 1'b1);
        drain_row(2'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFE);
        drain_row(2'd1, 32'h8000_0000, 32'd2);
`else
        drain_row(2'd0, 32'h8000_0010, 32'hFFFF_FFFE);
        drain_row(2'd1, 32'h7FFF_FFFF, 32'd2);
`endif
        drain_row(2'd2, 32'd3, 32'd3);
        drain_row(2'd3, 32'd3, 32'd3);
        check_idle("t6_after");
`ifdef ACC_BUF_SAT_EN
        check("t6_ovf_cleared", ovf, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
